// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and helpers for the pipeline checker
package riscv_pkg;
   localparam int NUM_CHECKS = 8;
   typedef enum logic [2:0] {
      CHK_PC_ALIGN, CHK_REDIR_ALIGN, CHK_MEM_RW, CHK_LU_MISS,
      CHK_FALSE_STALL, CHK_FWD_A, CHK_FWD_B, CHK_NEXT_PC
   } chk_id_e;
   typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} chk_state_e;
   function automatic logic [1:0] fwd_sel(input logic ex_w, input logic [4:0] ex_rd,
                                          input logic mem_w, input logic [4:0] mem_rd,
                                          input logic [4:0] rs);
      return (ex_w && ex_rd != 5'd0 && ex_rd == rs) ? 2'b10 :
             (mem_w && mem_rd != 5'd0 && mem_rd == rs) ? 2'b01 : 2'b00;
   endfunction
   function automatic chk_id_e first_id(input logic [NUM_CHECKS-1:0] v);
      first_id = CHK_PC_ALIGN;
      for (int k = NUM_CHECKS - 1; k >= 0; k--) if (v[k]) first_id = chk_id_e'(3'(k));
   endfunction
endpackage

// File: rtl/riscv_pipe_checker_if.sv
// riscv_pipe_checker_if: violation log head handshake
interface riscv_pipe_checker_if #(parameter int XLEN = 32, parameter int TS_W = 24);
   logic            log_valid;
   logic            log_ready;
   logic [2:0]      log_check_id;
   logic [XLEN-1:0] log_pc;
   logic [TS_W-1:0] log_ts;
   modport master(output log_valid, log_check_id, log_pc, log_ts, input log_ready);
   modport slave(input log_valid, log_check_id, log_pc, log_ts, output log_ready);
endinterface

// File: rtl/riscv_chk_fifo.sv
// riscv_chk_fifo: synchronous FIFO, 2**AW entries, accepts a push when full if a pop happens the same cycle
module riscv_chk_fifo #(parameter int W = 8, parameter int AW = 3) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wp, rp;
   logic         empty, full, push, pop;
   assign empty     = wp == rp;
   assign full      = wp == {~rp[AW], rp[AW-1:0]};
   assign pop       = out_ready && !empty;
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem[rp[AW-1:0]];
   // pointer update; the extra MSB separates full from empty
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   // storage write, no reset needed
   always_ff @(posedge clk)
      if (push) mem[wp[AW-1:0]] <= in_data;
endmodule

// File: rtl/riscv_pipe_checker.sv
// riscv_pipe_checker: per-cycle pipeline integrity checks with counters, violation log and halt request
module riscv_pipe_checker
   import riscv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_W     = 16,
   parameter int TS_W      = 24,
   parameter int LOG_DEPTH = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  cfg_en,
   input  logic                        cfg_stop_on_err,
   input  logic                        arm,
   input  logic                        clear,
   input  logic [XLEN-1:0]             if_id_pc,
   input  logic [XLEN-1:0]             core_pc,
   input  logic [XLEN-1:0]             redirect_pc,
   input  logic                        redirect_valid,
   input  logic                        stall_if,
   input  logic                        stall_id,
   input  logic                        flush_ex,
   input  logic                        mem_read,
   input  logic                        mem_write,
   input  logic                        hazard_ex_mem_read,
   input  logic [4:0]                  hazard_ex_rd,
   input  logic [4:0]                  id_rs1,
   input  logic [4:0]                  id_rs2,
   input  logic                        fwd_ex_reg_write,
   input  logic                        fwd_mem_reg_write,
   input  logic [4:0]                  fwd_ex_rd,
   input  logic [4:0]                  fwd_mem_rd,
   input  logic [4:0]                  id_ex_rs1,
   input  logic [4:0]                  id_ex_rs2,
   input  logic [1:0]                  forward_a,
   input  logic [1:0]                  forward_b,
   riscv_pipe_checker_if.master        log_if,
   output logic                        log_overflow,
   output logic [NUM_CHECKS*CNT_W-1:0] viol_cnt,
   output logic                        err_any,
   output logic [2:0]                  first_err_id,
   output logic [1:0]                  state,
   output logic                        halt_req
);
   chk_state_e                st;
   chk_id_e                   vid;
   logic                      wipe, lu, push, fifo_in_ready, pred_vld;
   logic [1:0]                exp_fa, exp_fb;
   logic [NUM_CHECKS-1:0]     raw, v;
   logic [XLEN-1:0]           pred;
   logic [TS_W-1:0]           ts;
   logic [CNT_W-1:0]          cnt [NUM_CHECKS];
   logic [3+XLEN+TS_W-1:0]    fifo_out;
   assign wipe   = rst || clear;
   assign lu     = hazard_ex_mem_read && hazard_ex_rd != 5'd0 &&
                   (hazard_ex_rd == id_rs1 || hazard_ex_rd == id_rs2);
   assign exp_fa = fwd_sel(fwd_ex_reg_write, fwd_ex_rd, fwd_mem_reg_write, fwd_mem_rd, id_ex_rs1);
   assign exp_fb = fwd_sel(fwd_ex_reg_write, fwd_ex_rd, fwd_mem_reg_write, fwd_mem_rd, id_ex_rs2);
   assign raw    = {pred_vld && core_pc != pred,
                    forward_b != exp_fb,
                    forward_a != exp_fa,
                    !lu && stall_if && stall_id,
                    lu && !(stall_if && stall_id && flush_ex),
                    mem_read && mem_write,
                    redirect_valid && redirect_pc[1:0] != 2'b00,
                    if_id_pc[1:0] != 2'b00};
   assign v      = raw & cfg_en & {NUM_CHECKS{st == ARMED}};
   assign push   = |v;
   assign vid    = first_id(v);
   assign state  = st;
   assign {log_if.log_check_id, log_if.log_pc, log_if.log_ts} = fifo_out;
   riscv_chk_fifo #(.W(3 + XLEN + TS_W), .AW(LOG_DEPTH)) u_log (
      .clk      (clk),
      .rst      (wipe),
      .in_valid (push),
      .in_ready (fifo_in_ready),
      .in_data  ({vid, core_pc, ts}),
      .out_valid(log_if.log_valid),
      .out_ready(log_if.log_ready),
      .out_data (fifo_out)
   );
   for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_cnt
      assign viol_cnt[i*CNT_W +: CNT_W] = cnt[i];
   end
   // saturating per-check violation counters
   always_ff @(posedge clk)
      for (int k = 0; k < NUM_CHECKS; k++)
         cnt[k] <= wipe ? '0 : (v[k] && !(&cnt[k])) ? cnt[k] + 1'b1 : cnt[k];
   // arm/trip FSM, timestamp, next-PC prediction and sticky error flags
   always_ff @(posedge clk)
      if (wipe) begin
         st           <= IDLE;
         halt_req     <= 1'b0;
         ts           <= '0;
         pred_vld     <= 1'b0;
         pred         <= '0;
         log_overflow <= 1'b0;
         err_any      <= 1'b0;
         first_err_id <= '0;
      end else begin
         if (push && !fifo_in_ready) log_overflow <= 1'b1;
         if (push && !err_any) begin
            err_any      <= 1'b1;
            first_err_id <= vid;
         end
         if (st == IDLE) begin
            ts       <= '0;
            pred_vld <= 1'b0;
            if (arm) st <= ARMED;
         end
         if (st == ARMED) begin
            ts       <= &ts ? ts : ts + 1'b1;
            pred_vld <= 1'b1;
            pred     <= stall_if ? core_pc : redirect_valid ? redirect_pc : core_pc + XLEN'(4);
            if (push && cfg_stop_on_err) begin
               st       <= TRIPPED;
               halt_req <= 1'b1;
            end
         end
      end
endmodule

// File: doc/riscv_pipe_checker.md
# riscv_pipe_checker

Synthesizable in-hardware pipeline checker for the RISC-V core. It evaluates a fixed set of eight pipeline-integrity checks every cycle and counts violations per check. It logs each violation (check id, PC, timestamp) into a FIFO that software or the bench drains through a valid/ready port. It sits beside the core, taps the same hazard, forwarding and PC signals the simulation assertions use, and can request a halt on the first error.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- CNT_W, 16, width of each per-check saturating violation counter
- TS_W, 24, timestamp width (cycles since arm)
- LOG_DEPTH, 3, log FIFO depth = 2**LOG_DEPTH entries

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- cfg_en  in  8  per-check enable mask, bit i = check i
- cfg_stop_on_err  in  1  enter TRIPPED on first enabled violation
- arm  in  1  single-cycle pulse, IDLE→ARMED
- clear  in  1  single-cycle pulse, return to IDLE and wipe all state
- if_id_pc, core_pc, redirect_pc  in  XLEN  pipeline PCs
- redirect_valid, stall_if, stall_id, flush_ex, mem_read, mem_write  in  1  pipeline controls
- hazard_ex_mem_read  in  1; hazard_ex_rd, id_rs1, id_rs2  in  5  load-use hazard inputs
- fwd_ex_reg_write, fwd_mem_reg_write  in  1; fwd_ex_rd, fwd_mem_rd, id_ex_rs1, id_ex_rs2  in  5  forwarding inputs
- forward_a, forward_b  in  2  forwarding mux selects under test
- log_valid  out  1; log_ready  in  1  log FIFO head handshake
- log_check_id  out  3; log_pc  out  XLEN; log_ts  out  TS_W  head entry fields, zero when empty
- log_overflow  out  1  sticky, an entry was dropped
- viol_cnt  out  8*CNT_W  flattened counters, check i at [i*CNT_W +: CNT_W]
- err_any  out  1  sticky, any enabled violation since clear
- first_err_id  out  3  id of the first logged violation
- state  out  2  chk_state_e
- halt_req  out  1  high while in TRIPPED

## Operation
- Checks run only in ARMED. Check i counts only when cfg_en[i]=1.
- Derived signals:
  - lu = hazard_ex_mem_read && hazard_ex_rd!=0 && (hazard_ex_rd==id_rs1 || hazard_ex_rd==id_rs2)
  - exp_fa = 2'b10 if fwd_ex_reg_write && fwd_ex_rd!=0 && fwd_ex_rd==id_ex_rs1; else 2'b01 if the same condition holds for the mem stage; else 2'b00. exp_fb is the same on id_ex_rs2.
- Checks:
  - 0 CHK_PC_ALIGN: if_id_pc[1:0]!=0
  - 1 CHK_REDIR_ALIGN: redirect_valid && redirect_pc[1:0]!=0
  - 2 CHK_MEM_RW: mem_read && mem_write
  - 3 CHK_LU_MISS: lu && !(stall_if && stall_id && flush_ex)
  - 4 CHK_FALSE_STALL: !lu && stall_if && stall_id
  - 5 CHK_FWD_A: forward_a!=exp_fa
  - 6 CHK_FWD_B: forward_b!=exp_fb
  - 7 CHK_NEXT_PC: core_pc!=pred. pred is registered from the previous cycle: prev core_pc if prev stall_if; else prev redirect_pc if prev redirect_valid; else prev core_pc+4, mod 2**XLEN. Check 7 is skipped on the first ARMED cycle (no previous sample).
- Counters: every enabled violating check increments its own counter in the same cycle. Counters saturate at all-ones.
- Log: at most one entry per cycle, the lowest-index violating check. The entry holds that id, the sampled core_pc, and the timestamp.
- The first logged violation after clear sets err_any and latches first_err_id. Later violations never overwrite first_err_id.
- FSM (chk_state_e):
  - IDLE=0: arm→ARMED. The timestamp counter and the pred-valid flag reset to 0.
  - ARMED=1: any enabled violation && cfg_stop_on_err→TRIPPED.
  - TRIPPED=2: checks, counters and timestamp freeze. The log still drains.
  - clear from any state→IDLE. clear has priority over arm.
- Reset and clear:
  - rst, and clear, zero every counter, the FIFO pointers, log_overflow, err_any and first_err_id.
  - On rst or clear: state=IDLE, halt_req=0, log_valid=0.

## Timing
- All outputs are registered. A violation sampled at edge N is visible at N+1: counters, log_valid/fields, err_any, state and halt_req all update on that edge.
- The timestamp is 0 on the first ARMED cycle, increments by 1 per ARMED cycle, and saturates at all-ones.
- Log pop: on log_valid && log_ready, the head advances at that edge.
- FIFO full: a push is dropped and log_overflow is set, unless a pop occurs in the same cycle, in which case the push is accepted. A simultaneous push and pop on an empty FIFO is a push only.
- rst mid-operation: all state is cleared on that edge. Outputs are at reset values the next cycle.

## Structure
- Add to riscv_pkg: NUM_CHECKS=8, the chk_id_e enum (CHK_PC_ALIGN..CHK_NEXT_PC, 3 bits), and the chk_state_e enum (IDLE, ARMED, TRIPPED, 2 bits).
- One sub-module: riscv_chk_fifo, a synchronous parametrised FIFO (width, depth) with a full/empty valid/ready interface, reused for the log.

## Test plan
- Arm, clean pipeline with core_pc stepping 0x100,0x104,0x108 → all viol_cnt=0, log_valid=0, err_any=0.
- if_id_pc=0x102 for 1 cycle with mem_read=mem_write=1 in the same cycle → cnt0=1, cnt2=1, a single log entry with id 0, first_err_id=0.
- hazard_ex_mem_read=1, hazard_ex_rd=5, id_rs2=5, stall_if=0 → cnt3=1. Repeat with hazard_ex_rd=0 and stall_if=stall_id=1 → cnt4=1.
- fwd_ex and fwd_mem both writing rd=7 = id_ex_rs1, forward_a=2'b01 → cnt5=1. Redirect 0x200 followed by core_pc=0x204 → cnt7=1, log_pc=0x204.
- cfg_stop_on_err=1, violation at cycle 3 after arm → state=TRIPPED next cycle, halt_req=1, log_ts=3, counters frozen; clear → IDLE, everything zero.
- LOG_DEPTH=3, 9 consecutive violations with log_ready=0 → 8 entries, log_overflow=1; pop all 8 → entries in order, then log_valid=0.
